lmfe_ctrl: RTL and testbench
============================

Name: lmfe_ctrl

Overview:
Filter controller that drives the 49-entry insert/delete median engine (lmfe_med49) to produce a 7x7 local-median-filtered image.
- Reads source pixels from an external two-read-port image RAM, in raster order.
- Generates the INS/DEL/SEN update stream for the engine.
- Samples MED once per output pixel and writes it to a result RAM.
- Sits between the image memories and the median engine in the LMFE top level.

Parameters:
W, 8, image width in pixels
H, 8, image height in pixels
AW, 6, RAM address width; must hold W*H-1 (address = y*W + x)

Ports:
clk  in  1  clock
RST  in  1  reset; one clock, asynchronous, active-high, shared with lmfe_med49
START  in  1  one-cycle start pulse; ignored while BUSY
RADDR_I  out  AW  read address, insert port
RDATA_I  in  8  read data, insert port; 1-cycle latency
RADDR_D  out  AW  read address, delete port
RDATA_D  in  8  read data, delete port; 1-cycle latency
SEN  out  1  engine no-op; high means no update this cycle
INS  out  8  insert value to engine
DEL  out  8  delete value to engine
MED  in  8  median from engine
WEN  out  1  result write strobe
WADDR  out  AW  result address
WDATA  out  8  result pixel
BUSY  out  1  high while processing
DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset values: SEN=1, INS=DEL=8'hff, RADDR_I=RADDR_D=0, WEN=0, WADDR=0, WDATA=0, BUSY=0, DONE=0, FSM=IDLE.
- Engine contract:
  - Engine empty = 49 entries of 8'hff.
  - INS<DEL: insert INS, remove DEL. INS>DEL: remove DEL, insert INS. INS==DEL: no-op.
  - SEN=1 forces a no-op. INS and DEL are driven 8'hff whenever SEN=1.
- Padding: any pixel coordinate outside 0..W-1 / 0..H-1 reads as 8'h00. No RAM access is needed for it; the RAM address is don't-care.
- Pipeline:
  - Cycle t: issue an update's addresses plus registered OOB flags.
  - Cycle t+1: SEN=0; INS/DEL = RDATA or pad or 8'hff (combinational from RDATA and registered flags).
  - Engine state updates at the end of t+1; MED reflects it in t+2.
- FSM: IDLE, FILL, SLIDE, FLUSH, FINISH.
  - IDLE: START -> FILL with y=0, x=0. BUSY rises in the next cycle; the first issue happens in that cycle.
  - FILL (49 issues, x=0): for dy=-3..3 outer, dx=-3..3 inner: INS=P(y+dy,dx), DEL=8'hff. -> SLIDE if W>1, else FLUSH.
  - SLIDE (7 issues per x, x=1..W-1): for dy=-3..3: INS=P(y+dy,x+3), DEL=P(y+dy,x-4). After x=W-1 -> FLUSH.
  - FLUSH (49 issues, final window, centre x=W-1): same order as FILL. INS=8'hff, DEL=P. Leaves engine empty. -> FILL for y+1, or FINISH after y=H-1.
  - FINISH: waits until the last flush update lands (2 cycles after issue). DONE=1 for one cycle, BUSY=0 next cycle -> IDLE.
- Issues are back-to-back; there are no bubbles between pixels or rows.
- Output write:
  - For the pixel whose last update issues at t_last, WDATA is MED sampled at the end of t_last+2.
  - WEN=1 and WADDR=y*W+x during t_last+3, exactly one cycle.
  - Overlapping next-pixel updates land only after the sample point.
- Totals: cycles per row = 49+7*(W-1)+49. Exactly W*H writes, in raster address order.
- RST mid-operation: everything returns to reset values immediately. The engine is reset by the same RST, so a new START runs cleanly.
- START while BUSY: ignored.

Decomposition:
- Package lmfe_pkg holds:
  - WIN=7, HALF=3, WIN_AREA=49
  - PAD=8'h00, EMPTY=8'hff
  - FSM state encoding
  - update-mode enum {FILL, SLIDE, FLUSH}
- Sub-module lmfe_addr_gen: signed (row, col) -> AW-bit address plus OOB flag. Instantiated twice, once per read port.

Test Plan:
- Constant 100 image, W=H=8 -> WDATA(0,0)=0; WDATA(3,0)=100 (28 of 49 in-bounds); WDATA(3,3)=100; WDATA(0,3)=100; 64 writes total.
- START at cycle 0 -> BUSY=1 at cycle 1; first WEN at cycle 52 with WADDR=0; second WEN at cycle 59 with WADDR=1; DONE at cycle 1178; BUSY=0 at cycle 1179.
- All-255 image -> interior WDATA=255, corner WDATA=0; after DONE, MED=8'hff (engine empty).
- Single 255 impulse at (3,3) in a zero image -> all 64 WDATA=0; no write address repeated or skipped.
- RST asserted mid-row 2 -> all outputs at reset values in the same cycle; re-START -> 64 correct writes matching a golden 7x7 zero-padded median model of a random image.
- START pulses while BUSY -> ignored; write count stays exactly 64; single DONE pulse.

Source files
------------

// File: rtl/lmfe_pkg.sv
// Shared constants, FSM encoding and update modes for the LMFE controller.
// Imported by the controller top and its address generator.
package lmfe_pkg;

    localparam int WIN      = 7;
    localparam int HALF     = 3;
    localparam int WIN_AREA = WIN * WIN;

    localparam logic [7:0] PAD   = 8'h00;
    localparam logic [7:0] EMPTY = 8'hff;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_SLIDE  = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [2:0] LAST_IDX = 3'(WIN - 1);

    typedef enum logic [1:0] {
        M_FILL,
        M_SLIDE,
        M_FLUSH
    } mode_t;

    typedef logic signed [15:0] coord_t;

    // Window index 0..6 to signed offset -3..3
    function automatic coord_t offs(input logic [2:0] idx);
        return coord_t'({13'd0, idx}) - coord_t'(HALF);
    endfunction

endpackage

// File: rtl/lmfe_addr_gen.sv
// Signed (row, col) to linear RAM address with an out-of-image flag.
// Out-of-image coordinates return address 0; the caller pads instead.
module lmfe_addr_gen
    import lmfe_pkg::*;
#(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int AW = 6
) (
    input  coord_t          i_row,
    input  coord_t          i_col,
    output logic [AW-1:0]   o_addr,
    output logic            o_oob
);

    logic w_oob;

    assign w_oob = (i_row < 0) || (i_row > coord_t'(H - 1))
                || (i_col < 0) || (i_col > coord_t'(W - 1));

    assign o_oob  = w_oob;
    assign o_addr = w_oob ? '0 : AW'(i_row * coord_t'(W) + i_col);

endmodule

// File: rtl/lmfe_ctrl.sv
// 7x7 local-median filter controller: walks the image in raster order,
// streams insert/delete updates to the median engine, writes MED out.
module lmfe_ctrl
    import lmfe_pkg::*;
#(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int AW = 6
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            START,
    output logic [AW-1:0]   RADDR_I,
    input  logic [7:0]      RDATA_I,
    output logic [AW-1:0]   RADDR_D,
    input  logic [7:0]      RDATA_D,
    output logic            SEN,
    output logic [7:0]      INS,
    output logic [7:0]      DEL,
    input  logic [7:0]      MED,
    output logic            WEN,
    output logic [AW-1:0]   WADDR,
    output logic [7:0]      WDATA,
    output logic            BUSY,
    output logic            DONE
);

    logic [2:0]     r_state;
    coord_t         r_y;
    coord_t         r_x;
    logic [2:0]     r_dy;
    logic [2:0]     r_dx;
    logic           r_busy;
    logic           r_done;
    logic           r_fin;

    logic           r_v1;
    mode_t          r_mode1;
    logic           r_ioob1;
    logic           r_doob1;
    logic           r_mk1;
    logic           r_mk2;
    logic [AW-1:0]  r_wa1;
    logic [AW-1:0]  r_wa2;

    logic           r_wen;
    logic [AW-1:0]  r_waddr;
    logic [7:0]     r_wdata;

    logic           w_issue;
    mode_t          w_mode;
    coord_t         w_row;
    coord_t         w_icol;
    coord_t         w_dcol;
    logic [AW-1:0]  w_iaddr;
    logic [AW-1:0]  w_daddr;
    logic           w_ioob;
    logic           w_doob;
    logic           w_last_win;
    logic           w_mark;
    logic [AW-1:0]  w_waddr;

    assign w_issue = (r_state == S_FILL)
                  || (r_state == S_SLIDE)
                  || (r_state == S_FLUSH);

    assign w_row      = r_y + offs(r_dy);
    assign w_last_win = (r_dy == LAST_IDX) && (r_dx == LAST_IDX);

    // A pixel's window is complete on the last FILL issue (x=0)
    // or on the last row of each SLIDE step (x>=1).
    assign w_mark = ((r_state == S_FILL) && w_last_win)
                 || ((r_state == S_SLIDE) && (r_dy == LAST_IDX));

    assign w_waddr = AW'(r_y * coord_t'(W) + r_x);

    // Update mode and column of each read port for the current issue
    always_comb begin
        w_mode = M_FILL;
        w_icol = '0;
        w_dcol = '0;
        unique case (r_state)
            S_FILL: begin
                w_mode = M_FILL;
                w_icol = offs(r_dx);
            end
            S_SLIDE: begin
                w_mode = M_SLIDE;
                w_icol = r_x + coord_t'(HALF);
                w_dcol = r_x - coord_t'(HALF + 1);
            end
            S_FLUSH: begin
                w_mode = M_FLUSH;
                w_dcol = r_x + offs(r_dx);
            end
            default: ;
        endcase
    end

    lmfe_addr_gen #(
        .W  (W),
        .H  (H),
        .AW (AW)
    ) u_ins_addr (
        .i_row  (w_row),
        .i_col  (w_icol),
        .o_addr (w_iaddr),
        .o_oob  (w_ioob)
    );

    lmfe_addr_gen #(
        .W  (W),
        .H  (H),
        .AW (AW)
    ) u_del_addr (
        .i_row  (w_row),
        .i_col  (w_dcol),
        .o_addr (w_daddr),
        .o_oob  (w_doob)
    );

    assign RADDR_I = (w_issue && (w_mode != M_FLUSH)) ? w_iaddr : '0;
    assign RADDR_D = (w_issue && (w_mode != M_FILL))  ? w_daddr : '0;

    // Sequencer: row/column/window counters and phase transitions
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_y     <= '0;
            r_x     <= '0;
            r_dy    <= '0;
            r_dx    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_state <= S_FILL;
                        r_busy  <= 1'b1;
                        r_y     <= '0;
                        r_x     <= '0;
                        r_dy    <= '0;
                        r_dx    <= '0;
                    end
                end
                S_FILL, S_FLUSH: begin
                    if (r_dx == LAST_IDX) begin
                        r_dx <= '0;
                        if (r_dy == LAST_IDX) begin
                            r_dy <= '0;
                            if (r_state == S_FILL) begin
                                r_state <= (W > 1) ? S_SLIDE : S_FLUSH;
                                r_x     <= (W > 1) ? 16'sd1 : 16'sd0;
                            end else if (r_y == coord_t'(H - 1)) begin
                                r_state <= S_FINISH;
                                r_fin   <= 1'b0;
                            end else begin
                                r_state <= S_FILL;
                                r_y     <= r_y + 16'sd1;
                                r_x     <= '0;
                            end
                        end else begin
                            r_dy <= r_dy + 3'd1;
                        end
                    end else begin
                        r_dx <= r_dx + 3'd1;
                    end
                end
                S_SLIDE: begin
                    if (r_dy == LAST_IDX) begin
                        r_dy <= '0;
                        if (r_x == coord_t'(W - 1)) begin
                            r_state <= S_FLUSH;
                        end else begin
                            r_x <= r_x + 16'sd1;
                        end
                    end else begin
                        r_dy <= r_dy + 3'd1;
                    end
                end
                S_FINISH: begin
                    // First cycle: last flush update lands; pulse DONE next
                    if (!r_fin) begin
                        r_fin  <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Delay line: pad flags for the data cycle, write marks to the sample point
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_v1    <= 1'b0;
            r_mode1 <= M_FILL;
            r_ioob1 <= 1'b0;
            r_doob1 <= 1'b0;
            r_mk1   <= 1'b0;
            r_mk2   <= 1'b0;
            r_wa1   <= '0;
            r_wa2   <= '0;
        end else begin
            r_v1    <= w_issue;
            r_mode1 <= w_mode;
            r_ioob1 <= w_ioob;
            r_doob1 <= w_doob;
            r_mk1   <= w_mark;
            r_mk2   <= r_mk1;
            r_wa1   <= w_waddr;
            r_wa2   <= r_wa1;
        end
    end

    // Engine update values: RAM data, pad, or EMPTY when not used
    always_comb begin
        SEN = 1'b1;
        INS = EMPTY;
        DEL = EMPTY;
        if (r_v1) begin
            SEN = 1'b0;
            if (r_mode1 != M_FLUSH) begin
                INS = r_ioob1 ? PAD : RDATA_I;
            end
            if (r_mode1 != M_FILL) begin
                DEL = r_doob1 ? PAD : RDATA_D;
            end
        end
    end

    // Result write: MED is sampled two cycles after the pixel's last issue
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= r_mk2;
            if (r_mk2) begin
                r_waddr <= r_wa2;
                r_wdata <= MED;
            end
        end
    end

    assign WEN   = r_wen;
    assign WADDR = r_waddr;
    assign WDATA = r_wdata;
    assign BUSY  = r_busy;
    assign DONE  = r_done;

endmodule

// File: tb/tb_lmfe_ctrl.sv
// Bench for lmfe_ctrl with image RAM and a histogram median engine.
// Expected writes are queued per run; a monitor pops them on WEN.
module tb_lmfe_ctrl;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 6;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          RST;
    logic          START;
    logic [AW-1:0] RADDR_I;
    logic [AW-1:0] RADDR_D;
    logic [7:0]    rd_i;
    logic [7:0]    rd_d;
    logic          SEN;
    logic [7:0]    INS;
    logic [7:0]    DEL;
    logic [7:0]    med_m;
    logic          WEN;
    logic [AW-1:0] WADDR;
    logic [7:0]    WDATA;
    logic          BUSY;
    logic          DONE;

    always #5 clk = ~clk;

    lmfe_ctrl #(.W(W), .H(H), .AW(AW)) dut (
        .clk     (clk),
        .RST     (RST),
        .START   (START),
        .RADDR_I (RADDR_I),
        .RDATA_I (rd_i),
        .RADDR_D (RADDR_D),
        .RDATA_D (rd_d),
        .SEN     (SEN),
        .INS     (INS),
        .DEL     (DEL),
        .MED     (med_m),
        .WEN     (WEN),
        .WADDR   (WADDR),
        .WDATA   (WDATA),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    logic [7:0] img [N];

    always @(posedge clk) begin
        rd_i <= img[RADDR_I];
        rd_d <= img[RADDR_D];
    end

    int ecnt [256];

    always @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int v = 0; v < 256; v++) ecnt[v] <= (v == 255) ? 49 : 0;
        end else if (!SEN && (INS != DEL)) begin
            ecnt[DEL] <= ecnt[DEL] - 1;
            ecnt[INS] <= ecnt[INS] + 1;
        end
    end

    int  acc;
    bit  fnd;
    always_comb begin
        med_m = 8'hff;
        acc   = 0;
        fnd   = 1'b0;
        for (int v = 0; v < 256; v++) begin
            acc = acc + ecnt[v];
            if (!fnd && acc >= 25) begin
                med_m = 8'(v);
                fnd   = 1'b1;
            end
        end
    end

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   c0    = 0;
    int   wr_cnt;
    int   done_cnt;
    int   w0;
    int   w1;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Monitor: every WEN pops one expected write
    always @(negedge clk) begin
        exp_t e;
        if (DONE) done_cnt++;
        if (WEN) begin
            if (wr_cnt == 0) w0 = cyc - c0;
            if (wr_cnt == 1) w1 = cyc - c0;
            wr_cnt++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_write: addr %0d not expected", WADDR);
            end else begin
                e = q.pop_front();
                chk("waddr", int'(WADDR), e.addr);
                chk($sformatf("wdata@%0d", e.addr), int'(WDATA), e.data);
            end
        end
    end

    function automatic int pix(input int y, input int x);
        if (y < 0 || y >= H || x < 0 || x >= W) return 0;
        return int'(img[y * W + x]);
    endfunction

    function automatic int med7(input int y, input int x);
        int h [256];
        int a;
        foreach (h[i]) h[i] = 0;
        for (int dy = -3; dy <= 3; dy++)
            for (int dx = -3; dx <= 3; dx++)
                h[pix(y + dy, x + dx)]++;
        a = 0;
        for (int v = 0; v < 256; v++) begin
            a = a + h[v];
            if (a >= 25) return v;
        end
        return 255;
    endfunction

    // Constant image: median is v when 25+ of 49 taps are in-image
    task automatic push_const(input int v);
        exp_t e;
        int   ny, nx;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                ny = ((y + 3 < H) ? y + 3 : H - 1) - ((y - 3 > 0) ? y - 3 : 0) + 1;
                nx = ((x + 3 < W) ? x + 3 : W - 1) - ((x - 3 > 0) ? x - 3 : 0) + 1;
                e.addr = y * W + x;
                e.data = (ny * nx >= 25) ? v : 0;
                q.push_back(e);
            end
    endtask

    task automatic push_golden();
        exp_t e;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                e.addr = y * W + x;
                e.data = med7(y, x);
                q.push_back(e);
            end
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_sen"},   int'(SEN),     1);
        chk({t, "_ins"},   int'(INS),     255);
        chk({t, "_del"},   int'(DEL),     255);
        chk({t, "_raddri"}, int'(RADDR_I), 0);
        chk({t, "_raddrd"}, int'(RADDR_D), 0);
        chk({t, "_wen"},   int'(WEN),     0);
        chk({t, "_waddr"}, int'(WADDR),   0);
        chk({t, "_wdata"}, int'(WDATA),   0);
        chk({t, "_busy"},  int'(BUSY),    0);
        chk({t, "_done"},  int'(DONE),    0);
    endtask

    task automatic run_img(input bit timing, input bit spam, input int abort_at);
        bit got;
        int dcyc;
        got      = 1'b0;
        dcyc     = -1;
        wr_cnt   = 0;
        done_cnt = 0;
        w0       = -1;
        w1       = -1;
        @(posedge clk);
        #1 START = 1'b1;
        c0 = cyc;
        @(negedge clk);
        if (timing) chk("busy_cyc0", int'(BUSY), 0);
        @(posedge clk);
        #1 START = 1'b0;
        @(negedge clk);
        if (timing) chk("busy_cyc1", int'(BUSY), 1);
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            START = spam && (i % 300 == 7);
            if (abort_at > 0 && i == abort_at) begin
                START = 1'b0;
                @(posedge clk);
                #2 RST = 1'b1;
                #1 chk_reset("midrst");
                q.delete();
                @(posedge clk);
                #1 RST = 1'b0;
                return;
            end
            if (DONE) begin
                got  = 1'b1;
                dcyc = cyc - c0;
            end
        end
        START = 1'b0;
        chk("done_seen", int'(got), 1);
        @(negedge clk);
        chk("busy_after_done", int'(BUSY), 0);
        if (timing) begin
            chk("done_cyc", dcyc, 1178);
            chk("busy_fall_cyc", cyc - c0, 1179);
            chk("first_wen_cyc", w0, 52);
            chk("second_wen_cyc", w1, 59);
        end
        repeat (3) @(negedge clk);
        chk("write_count", wr_cnt, N);
        chk("sb_left", q.size(), 0);
        chk("done_pulses", done_cnt, 1);
        q.delete();
    endtask

    initial begin
        RST   = 1'b1;
        START = 1'b0;
        wr_cnt   = 0;
        done_cnt = 0;
        foreach (img[i]) img[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1 RST = 1'b0;
        @(negedge clk);
        chk_reset("init");

        foreach (img[i]) img[i] = 8'd100;
        push_const(100);
        run_img(1'b1, 1'b0, 0);

        foreach (img[i]) img[i] = 8'd255;
        push_const(255);
        run_img(1'b0, 1'b0, 0);
        chk("med_empty", int'(med_m), 255);

        foreach (img[i]) img[i] = 8'd0;
        img[3 * W + 3] = 8'd255;
        push_const(0);
        run_img(1'b0, 1'b0, 0);

        foreach (img[i]) img[i] = 8'($urandom_range(0, 255));
        push_golden();
        run_img(1'b0, 1'b0, 368);
        push_golden();
        run_img(1'b0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
